// File: rtl/incubator_pkg.sv
// Shared definitions for the incubator actuator path: operating modes,
// nominal fan levels and the fan-level saturation helper.
package incubator_pkg;

  // Operating modes of the actuator driver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOL  = 2'd1,
    HEAT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Fan levels the temperature controller issues in normal operation.
  typedef enum logic [3:0] {
    CRS_OFF  = 4'd0,
    CRS_LOW  = 4'd4,
    CRS_MID  = 4'd6,
    CRS_HIGH = 4'd8
  } crs_level_e;

  // Clamp a requested fan level to the largest duty the PWM can express.
  function automatic logic [31:0] sat_level(input logic [3:0]  level,
                                            input logic [31:0] max_level);
    logic [31:0] ext;
    ext = {28'd0, level};
    return (ext > max_level) ? max_level : ext;
  endfunction

endpackage

// File: rtl/incubator_actuator_driver_pwm_gen.sv
// pwm_gen: free-running period counter, period-boundary strobe and the
// registered duty compare that produces the fan PWM.
module pwm_gen #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] duty,
  output logic             wrap,
  output logic             fan_pwm
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fan_pwm_q, fan_pwm_d;

  // Next count and compare; high while the count is below the applied duty.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d     = cnt_q + CNT_ONE;
    fan_pwm_d = (cnt_q < duty);
  end

  // Counter and PWM output registers.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low; it only takes effect on a clock edge.
    if (!reset) begin
      cnt_q     <= '0;
      fan_pwm_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      fan_pwm_q <= fan_pwm_d;
    end
  end

  // Boundary strobe: the edge at which the counter rolls over to zero.
  assign wrap    = (cnt_q == '1);
  assign fan_pwm = fan_pwm_q;

endmodule

// File: rtl/incubator_actuator_driver.sv
// incubator_actuator_driver: turns heater/cooler requests and a fan level
// into a ramped fan PWM and a heater drive with minimum off-time, and
// latches a fault when heating and cooling are requested together.
module incubator_actuator_driver
  import incubator_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int RAMP_DIV = 2,
  parameter int MIN_OFF  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             heater_req,
  input  logic             cooler_req,
  input  logic [3:0]       crs,
  output logic             fan_pwm,
  output logic             heater_drv,
  output logic [CNT_W-1:0] duty_now,
  output logic             at_target,
  output logic             fault
);

  localparam int                RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_ONE  = RAMP_W'(1);
  localparam int                HOLD_W    = $clog2(MIN_OFF + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_OFF);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  DUTY_ONE  = CNT_W'(1);
  localparam logic [31:0]       DUTY_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  duty_q, duty_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              heater_drv_q, heater_drv_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  target;
  logic              wrap;

  pwm_gen #(
    .CNT_W (CNT_W)
  ) u_pwm_gen (
    .clk     (clk),
    .reset   (reset),
    .duty    (duty_q),
    .wrap    (wrap),
    .fan_pwm (fan_pwm)
  );

  // Target duty: the saturated fan level while cooling is requested, zero
  // whenever the heater owns the plant or a fault has been latched.
  always_comb begin
    target = '0;
    if (cooler_req && (state_q != HEAT) && (state_q != FAULT)) begin
      target = CNT_W'(sat_level(crs, DUTY_MAX));
    end
  end

  // Mode sequencing; COOL only hands over to HEAT once the fan has stopped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (heater_req && cooler_req) state_d = FAULT;
        else if (heater_req)          state_d = HEAT;
        else if (cooler_req)          state_d = COOL;
      end
      COOL: begin
        if (heater_req && cooler_req) state_d = FAULT;
        else if (heater_req)          state_d = (duty_q == '0) ? HEAT : COOL;
        else if (!cooler_req)         state_d = IDLE;
      end
      HEAT: begin
        if (heater_req && cooler_req) state_d = FAULT;
        else if (!heater_req)         state_d = IDLE;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Duty ramp: one step toward target on every RAMP_DIV-th period boundary.
  always_comb begin
    ramp_d = ramp_q;
    duty_d = duty_q;
    if (wrap) begin
      if (ramp_q == RAMP_LAST) begin
        ramp_d = '0;
        if (duty_q < target)      duty_d = duty_q + DUTY_ONE;
        else if (duty_q > target) duty_d = duty_q - DUTY_ONE;
      end else begin
        ramp_d = ramp_q + RAMP_ONE;
      end
    end
  end

  // Heater drive with off-time hold-off; it is never on while the fan duty
  // is non-zero, and the hold-off reloads on every falling edge of the drive.
  always_comb begin
    heater_drv_d = (state_d == HEAT) && (hold_q == '0) && (duty_d == '0);
    hold_d       = hold_q;
    if (heater_drv_q && !heater_drv_d) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_ONE;
    end
    fault_d = fault_q || (state_d == FAULT);
  end

  // State, ramp, hold-off and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      ramp_q       <= '0;
      hold_q       <= '0;
      heater_drv_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      ramp_q       <= ramp_d;
      hold_q       <= hold_d;
      heater_drv_q <= heater_drv_d;
      fault_q      <= fault_d;
    end
  end

  assign heater_drv = heater_drv_q;
  assign duty_now   = duty_q;
  assign at_target  = (duty_q == target);
  assign fault      = fault_q;

endmodule
